alu_exec_unit: RTL and testbench
================================

Name: alu_exec_unit

Overview:
- RV32I integer execute datapath: decodes a 3-bit ALU class plus instruction func3/func7 into a 4-bit ALU control code, then computes the 32-bit result and branch-taken mark.
- Sits in the EX stage after operand selection and forwarding muxes.
- Outputs are registered: one-cycle latency into the EX/MEM boundary.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; asynchronous, active-high
- en  in  1  capture enable; when 0, all output registers hold
- in_valid  in  1  operands and opcode valid this cycle
- alu_op  in  3  ALU class from the main decoder
- func3  in  3  instruction bits [14:12]
- func7  in  1  instruction bit 30
- op_a  in  32  operand A, already forwarded/selected
- op_b  in  32  operand B, already forwarded/selected
- out_valid  out  1  registered in_valid
- alu_o  out  32  registered result
- br_mark  out  1  registered branch condition true
- alu_ctrl_q  out  4  registered control code, for debug/trace

Behaviour:
- Reset (async, rst=1): out_valid=0, alu_o=0, br_mark=0, alu_ctrl_q=0 (ADD).
- Capture rule: on each rising clk with rst=0 and en=1, all outputs register the combinational decode/compute of the current inputs, and out_valid<=in_valid. Latency is exactly 1 cycle.
- en=0: everything holds, including out_valid.
- Results are computed regardless of in_valid.
- Control code encodings (4 bits, all 16 used): ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, BEQ=10, BNE=11, BLT=12, BGE=13, BLTU=14, BGEU=15.
- alu_op=000 (load/store/jal/jalr/auipc/lui): ADD.
- alu_op=001 (branch), by func3:
  - 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
  - 010 and 011 decode to ADD, so br_mark=0.
- alu_op=010 (R-type), by func3:
  - 000: func7 ? SUB : ADD.
  - 001 SLL, 010 SLT, 011 SLTU, 100 XOR.
  - 101: func7 ? SRA : SRL.
  - 110 OR, 111 AND.
- alu_op=011 (I-type arithmetic): same as R-type, except func3=000 is always ADD (func7 ignored, since imm bit 30 may be set).
- alu_op=100..111: ADD.
- Arithmetic:
  - ADD/SUB wrap modulo 2^32.
  - Shifts use op_b[4:0] only; SRA sign-fills.
  - SLT compares signed; SLTU compares unsigned; both give a 0/1 result zero-extended.
- Branch codes:
  - br_mark = condition (EQ, NE, signed LT/GE, unsigned LT/GE).
  - alu_o = {31'b0, br_mark}.
- Non-branch codes: br_mark=0.

Optional Feature:
- Macro ALU_OVF_FLAG_EN.
- When defined: adds output port ovf (1 bit, registered with the other outputs, reset 0). ovf is signed overflow for ADD/SUB and 0 for every other code.
- When undefined: no ovf port and no overflow logic.

Decomposition:
- Shared package alu_pkg holds:
  - the 4-bit ALU control code constants above;
  - alu_op class constants (ALU_ADD=000, ALU_BR=001, ALU_R=010, ALU_I=011, ALU_LUI=100).
- Natural sub-module: alu_decode, purely combinational, mapping alu_op/func3/func7 to the control code.
- The result mux and output registers live in the top.

Test Plan:
- Reset while in_valid=1, en=1 -> all outputs 0 immediately (async) and held until rst deasserts.
- alu_op=010, func3=000, func7=1, op_a=5, op_b=7 -> next cycle alu_o=0xFFFFFFFE, alu_ctrl_q=SUB, br_mark=0, out_valid=1.
- alu_op=011, func3=101, func7=1, op_a=0x80000000, op_b=0x404 -> alu_o=0xF8000000 (SRA by 4).
- alu_op=011, func3=000, func7=1, op_a=3, op_b=0xFFFFFC00 -> ADD, alu_o=0xFFFFFC03.
- alu_op=001, func3=100, op_a=0xFFFFFFFF, op_b=1 -> br_mark=1, alu_o=1 (BLT). Same operands with func3=110 -> br_mark=0 (BLTU).
- en=0 for 2 cycles with changing inputs -> outputs unchanged.
- With ALU_OVF_FLAG_EN: ADD 0x7FFFFFFF+1 -> ovf=1, alu_o=0x80000000.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU control codes and alu_op class constants
package alu_pkg;

  typedef logic [3:0] alu_ctrl_t;

  localparam alu_ctrl_t CTRL_ADD  = 4'd0;
  localparam alu_ctrl_t CTRL_SUB  = 4'd1;
  localparam alu_ctrl_t CTRL_SLL  = 4'd2;
  localparam alu_ctrl_t CTRL_SLT  = 4'd3;
  localparam alu_ctrl_t CTRL_SLTU = 4'd4;
  localparam alu_ctrl_t CTRL_XOR  = 4'd5;
  localparam alu_ctrl_t CTRL_SRL  = 4'd6;
  localparam alu_ctrl_t CTRL_SRA  = 4'd7;
  localparam alu_ctrl_t CTRL_OR   = 4'd8;
  localparam alu_ctrl_t CTRL_AND  = 4'd9;
  localparam alu_ctrl_t CTRL_BEQ  = 4'd10;
  localparam alu_ctrl_t CTRL_BNE  = 4'd11;
  localparam alu_ctrl_t CTRL_BLT  = 4'd12;
  localparam alu_ctrl_t CTRL_BGE  = 4'd13;
  localparam alu_ctrl_t CTRL_BLTU = 4'd14;
  localparam alu_ctrl_t CTRL_BGEU = 4'd15;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_BR  = 3'b001;
  localparam logic [2:0] ALU_R   = 3'b010;
  localparam logic [2:0] ALU_I   = 3'b011;
  localparam logic [2:0] ALU_LUI = 3'b100;

  // Branch codes occupy the top of the code space (10..15).
  function automatic logic is_branch(input alu_ctrl_t c);
    return c >= CTRL_BEQ;
  endfunction

endpackage

// File: rtl/alu_decode.sv
// rtl/alu_decode.sv - maps alu_op/func3/func7 to the 4-bit ALU control code
module alu_decode
  import alu_pkg::*;
(
  input  logic [2:0] alu_op_i,
  input  logic [2:0] func3_i,
  input  logic       func7_i,
  output alu_ctrl_t  ctrl_o
);

  always_comb begin
    ctrl_o = CTRL_ADD;
    case (alu_op_i)
      ALU_BR: begin
        case (func3_i)
          3'b000:  ctrl_o = CTRL_BEQ;
          3'b001:  ctrl_o = CTRL_BNE;
          3'b100:  ctrl_o = CTRL_BLT;
          3'b101:  ctrl_o = CTRL_BGE;
          3'b110:  ctrl_o = CTRL_BLTU;
          3'b111:  ctrl_o = CTRL_BGEU;
          default: ctrl_o = CTRL_ADD;
        endcase
      end
      ALU_R, ALU_I: begin
        case (func3_i)
          // I-type ADDI carries immediate bit 30 in func7, so only R-type may select SUB.
          3'b000:  ctrl_o = (alu_op_i == ALU_R && func7_i) ? CTRL_SUB : CTRL_ADD;
          3'b001:  ctrl_o = CTRL_SLL;
          3'b010:  ctrl_o = CTRL_SLT;
          3'b011:  ctrl_o = CTRL_SLTU;
          3'b100:  ctrl_o = CTRL_XOR;
          3'b101:  ctrl_o = func7_i ? CTRL_SRA : CTRL_SRL;
          3'b110:  ctrl_o = CTRL_OR;
          default: ctrl_o = CTRL_AND;
        endcase
      end
      default: ctrl_o = CTRL_ADD;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - RV32I EX-stage ALU with registered result and branch mark
// Optional signed-overflow output enabled by ALU_OVF_FLAG_EN.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            in_valid,
  input  logic [2:0]      alu_op,
  input  logic [2:0]      func3,
  input  logic            func7,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  output logic [XLEN-1:0] alu_o,
  output logic            br_mark,
  output logic [3:0]      alu_ctrl_q
`ifdef ALU_OVF_FLAG_EN
  ,
  output logic            ovf
`endif
);

  alu_ctrl_t       ctrl_d;
  logic [XLEN-1:0] sum, diff, alu_d;
  logic [4:0]      shamt;
  logic            lt_s, lt_u, eq, br_d;
  logic            valid_q, br_q;
  logic [XLEN-1:0] alu_q;

  alu_decode u_decode (
    .alu_op_i (alu_op),
    .func3_i  (func3),
    .func7_i  (func7),
    .ctrl_o   (ctrl_d)
  );

  assign sum   = op_a + op_b;
  assign diff  = op_a - op_b;
  assign shamt = op_b[4:0];
  assign lt_s  = $signed(op_a) < $signed(op_b);
  assign lt_u  = op_a < op_b;
  assign eq    = op_a == op_b;

  always_comb begin
    br_d = 1'b0;
    case (ctrl_d)
      CTRL_BEQ:  br_d = eq;
      CTRL_BNE:  br_d = !eq;
      CTRL_BLT:  br_d = lt_s;
      CTRL_BGE:  br_d = !lt_s;
      CTRL_BLTU: br_d = lt_u;
      CTRL_BGEU: br_d = !lt_u;
      default:   br_d = 1'b0;
    endcase
  end

  always_comb begin
    alu_d = sum;
    case (ctrl_d)
      CTRL_SUB:  alu_d = diff;
      CTRL_SLL:  alu_d = op_a << shamt;
      CTRL_SLT:  alu_d = {{(XLEN-1){1'b0}}, lt_s};
      CTRL_SLTU: alu_d = {{(XLEN-1){1'b0}}, lt_u};
      CTRL_XOR:  alu_d = op_a ^ op_b;
      CTRL_SRL:  alu_d = op_a >> shamt;
      CTRL_SRA:  alu_d = $signed(op_a) >>> shamt;
      CTRL_OR:   alu_d = op_a | op_b;
      CTRL_AND:  alu_d = op_a & op_b;
      default:   alu_d = sum;
    endcase
    if (is_branch(ctrl_d)) alu_d = {{(XLEN-1){1'b0}}, br_d};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= 1'b0;
      alu_q      <= '0;
      br_q       <= 1'b0;
      alu_ctrl_q <= CTRL_ADD;
    end else if (en) begin
      valid_q    <= in_valid;
      alu_q      <= alu_d;
      br_q       <= br_d;
      alu_ctrl_q <= ctrl_d;
    end
  end

  assign out_valid = valid_q;
  assign alu_o     = alu_q;
  assign br_mark   = br_q;

`ifdef ALU_OVF_FLAG_EN
  logic ovf_d, ovf_q;

  // Overflow when same-sign addends (or opposite-sign SUB operands) give a result of the other sign.
  always_comb begin
    ovf_d = 1'b0;
    if (ctrl_d == CTRL_ADD)
      ovf_d = (op_a[XLEN-1] == op_b[XLEN-1]) && (sum[XLEN-1] != op_a[XLEN-1]);
    else if (ctrl_d == CTRL_SUB)
      ovf_d = (op_a[XLEN-1] != op_b[XLEN-1]) && (diff[XLEN-1] != op_a[XLEN-1]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     ovf_q <= 1'b0;
    else if (en) ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - directed self-checking bench for alu_exec_unit
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst, en, in_valid, func7;
  logic [2:0]  alu_op, func3;
  logic [31:0] op_a, op_b;
  logic        out_valid, br_mark;
  logic [31:0] alu_o;
  logic [3:0]  alu_ctrl_q;
`ifdef ALU_OVF_FLAG_EN
  logic        ovf;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctrl;
    logic        br;
    logic [31:0] res;
  } vec_t;

  alu_exec_unit dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .in_valid   (in_valid),
    .alu_op     (alu_op),
    .func3      (func3),
    .func7      (func7),
    .op_a       (op_a),
    .op_b       (op_b),
    .out_valid  (out_valid),
    .alu_o      (alu_o),
    .br_mark    (br_mark),
    .alu_ctrl_q (alu_ctrl_q)
`ifdef ALU_OVF_FLAG_EN
    ,
    .ovf        (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic drive(input vec_t v, input logic valid);
    alu_op = v.op; func3 = v.f3; func7 = v.f7;
    op_a = v.a; op_b = v.b; in_valid = valid; en = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    logic [37:0] got;
    rst = 1'b1; en = 1'b1; in_valid = 1'b1;
    alu_op = 3'b010; func3 = 3'b000; func7 = 1'b1; op_a = 32'd5; op_b = 32'd7;
    #1;
    got = {out_valid, br_mark, alu_ctrl_q, alu_o}; checks++;
    if (got !== 38'd0) begin errors++; $display("FAIL reset_initial got=%h exp=0", got); end
    @(posedge clk); #1;
    got = {out_valid, br_mark, alu_ctrl_q, alu_o}; checks++;
    if (got !== 38'd0) begin errors++; $display("FAIL reset_held got=%h exp=0", got); end
    rst = 1'b0;
    @(posedge clk); #1;
    got = {out_valid, br_mark, alu_ctrl_q, alu_o}; checks++;
    if (got !== {1'b1, 1'b0, 4'd1, 32'hFFFFFFFE}) begin
      errors++; $display("FAIL reset_release_sub got=%h exp=%h", got, {1'b1, 1'b0, 4'd1, 32'hFFFFFFFE});
    end
    #2 rst = 1'b1;
    #1;
    got = {out_valid, br_mark, alu_ctrl_q, alu_o}; checks++;
    if (got !== 38'd0) begin errors++; $display("FAIL reset_async got=%h exp=0", got); end
    @(posedge clk); #1;
    got = {out_valid, br_mark, alu_ctrl_q, alu_o}; checks++;
    if (got !== 38'd0) begin errors++; $display("FAIL reset_async_held got=%h exp=0", got); end
    rst = 1'b0;
  endtask

  task automatic test_r_type;
    vec_t q[$];
    logic [37:0] got, exp;
    q.push_back('{"r_add_wrap", 3'b010, 3'b000, 1'b0, 32'hFFFFFFFF, 32'd2,        4'd0, 1'b0, 32'h00000001});
    q.push_back('{"r_sub",      3'b010, 3'b000, 1'b1, 32'd5,        32'd7,        4'd1, 1'b0, 32'hFFFFFFFE});
    q.push_back('{"r_sll",      3'b010, 3'b001, 1'b0, 32'd1,        32'h21,       4'd2, 1'b0, 32'h00000002});
    q.push_back('{"r_slt",      3'b010, 3'b010, 1'b0, 32'hFFFFFFFF, 32'd1,        4'd3, 1'b0, 32'h00000001});
    q.push_back('{"r_sltu",     3'b010, 3'b011, 1'b0, 32'hFFFFFFFF, 32'd1,        4'd4, 1'b0, 32'h00000000});
    q.push_back('{"r_xor",      3'b010, 3'b100, 1'b0, 32'h0000F0F0, 32'h0000FF00, 4'd5, 1'b0, 32'h00000FF0});
    q.push_back('{"r_srl",      3'b010, 3'b101, 1'b0, 32'h80000000, 32'd4,        4'd6, 1'b0, 32'h08000000});
    q.push_back('{"r_sra",      3'b010, 3'b101, 1'b1, 32'h80000000, 32'h24,       4'd7, 1'b0, 32'hF8000000});
    q.push_back('{"r_or",       3'b010, 3'b110, 1'b0, 32'h0000F0F0, 32'h0000FF00, 4'd8, 1'b0, 32'h0000FFF0});
    q.push_back('{"r_and",      3'b010, 3'b111, 1'b0, 32'h0000F0F0, 32'h0000FF00, 4'd9, 1'b0, 32'h0000F000});
    foreach (q[i]) begin
      drive(q[i], 1'b1);
      got = {out_valid, br_mark, alu_ctrl_q, alu_o};
      exp = {1'b1, q[i].br, q[i].ctrl, q[i].res};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL %s got=%h exp=%h", q[i].name, got, exp); end
    end
  endtask

  task automatic test_i_type;
    vec_t q[$];
    logic [37:0] got, exp;
    q.push_back('{"i_srai",      3'b011, 3'b101, 1'b1, 32'h80000000, 32'h00000404, 4'd7, 1'b0, 32'hF8000000});
    q.push_back('{"i_addi_f7",   3'b011, 3'b000, 1'b1, 32'd3,        32'hFFFFFC00, 4'd0, 1'b0, 32'hFFFFFC03});
    q.push_back('{"i_srli_31",   3'b011, 3'b101, 1'b0, 32'hFFFFFFFF, 32'h0000001F, 4'd6, 1'b0, 32'h00000001});
    q.push_back('{"i_slti_neg",  3'b011, 3'b010, 1'b0, 32'd5,        32'hFFFFFFFB, 4'd3, 1'b0, 32'h00000000});
    foreach (q[i]) begin
      drive(q[i], 1'b1);
      got = {out_valid, br_mark, alu_ctrl_q, alu_o};
      exp = {1'b1, q[i].br, q[i].ctrl, q[i].res};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL %s got=%h exp=%h", q[i].name, got, exp); end
    end
  endtask

  task automatic test_branch;
    vec_t q[$];
    logic [37:0] got, exp;
    q.push_back('{"br_blt",     3'b001, 3'b100, 1'b0, 32'hFFFFFFFF, 32'd1, 4'd12, 1'b1, 32'd1});
    q.push_back('{"br_bltu",    3'b001, 3'b110, 1'b0, 32'hFFFFFFFF, 32'd1, 4'd14, 1'b0, 32'd0});
    q.push_back('{"br_bge",     3'b001, 3'b101, 1'b0, 32'hFFFFFFFF, 32'd1, 4'd13, 1'b0, 32'd0});
    q.push_back('{"br_bgeu",    3'b001, 3'b111, 1'b0, 32'hFFFFFFFF, 32'd1, 4'd15, 1'b1, 32'd1});
    q.push_back('{"br_beq_t",   3'b001, 3'b000, 1'b0, 32'd7,        32'd7, 4'd10, 1'b1, 32'd1});
    q.push_back('{"br_bne_nt",  3'b001, 3'b001, 1'b1, 32'd7,        32'd7, 4'd11, 1'b0, 32'd0});
    q.push_back('{"br_beq_nt",  3'b001, 3'b000, 1'b0, 32'd7,        32'd8, 4'd10, 1'b0, 32'd0});
    q.push_back('{"br_f3_010",  3'b001, 3'b010, 1'b0, 32'd1,        32'd2, 4'd0,  1'b0, 32'd3});
    q.push_back('{"br_f3_011",  3'b001, 3'b011, 1'b1, 32'hFFFFFFFF, 32'd1, 4'd0,  1'b0, 32'd0});
    foreach (q[i]) begin
      drive(q[i], 1'b1);
      got = {out_valid, br_mark, alu_ctrl_q, alu_o};
      exp = {1'b1, q[i].br, q[i].ctrl, q[i].res};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL %s got=%h exp=%h", q[i].name, got, exp); end
    end
  endtask

  task automatic test_other_classes;
    vec_t q[$];
    logic [37:0] got, exp;
    q.push_back('{"op000_add", 3'b000, 3'b101, 1'b1, 32'd10,        32'd20,        4'd0, 1'b0, 32'd30});
    q.push_back('{"op100_lui", 3'b100, 3'b000, 1'b0, 32'h12345000,  32'h00000678,  4'd0, 1'b0, 32'h12345678});
    q.push_back('{"op111_add", 3'b111, 3'b001, 1'b1, 32'hFFFFFFFF,  32'hFFFFFFFF,  4'd0, 1'b0, 32'hFFFFFFFE});
    foreach (q[i]) begin
      drive(q[i], 1'b1);
      got = {out_valid, br_mark, alu_ctrl_q, alu_o};
      exp = {1'b1, q[i].br, q[i].ctrl, q[i].res};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL %s got=%h exp=%h", q[i].name, got, exp); end
    end
  endtask

  task automatic test_back_to_back;
    vec_t q[$];
    logic vld[3];
    logic [37:0] got, exp;
    vld[0] = 1'b1; vld[1] = 1'b0; vld[2] = 1'b1;
    q.push_back('{"b2b_0_sub",  3'b010, 3'b000, 1'b1, 32'd100,      32'd1,  4'd1,  1'b0, 32'd99});
    q.push_back('{"b2b_1_inv",  3'b010, 3'b100, 1'b0, 32'hAAAAAAAA, 32'hFFFFFFFF, 4'd5, 1'b0, 32'h55555555});
    q.push_back('{"b2b_2_bne",  3'b001, 3'b001, 1'b0, 32'd1,        32'd2,  4'd11, 1'b1, 32'd1});
    foreach (q[i]) begin
      drive(q[i], vld[i]);
      got = {out_valid, br_mark, alu_ctrl_q, alu_o};
      exp = {vld[i], q[i].br, q[i].ctrl, q[i].res};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL %s got=%h exp=%h", q[i].name, got, exp); end
    end
  endtask

  task automatic test_enable_hold;
    vec_t v;
    logic [37:0] got, exp;
    v = '{"hold_xor", 3'b010, 3'b100, 1'b0, 32'h0000F0F0, 32'h0000FF00, 4'd5, 1'b0, 32'h00000FF0};
    drive(v, 1'b1);
    exp = {1'b1, 1'b0, 4'd5, 32'h00000FF0};
    en = 1'b0;
    for (int c = 0; c < 2; c++) begin
      in_valid = 1'b0; alu_op = 3'b001; func3 = 3'(c); func7 = 1'b1;
      op_a = 32'h1000 + 32'(c); op_b = 32'h1000 + 32'(c);
      @(posedge clk); #1;
      got = {out_valid, br_mark, alu_ctrl_q, alu_o};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL en_hold_cycle%0d got=%h exp=%h", c, got, exp); end
    end
    en = 1'b1;
    @(posedge clk); #1;
    got = {out_valid, br_mark, alu_ctrl_q, alu_o};
    checks++;
    if (got !== {1'b0, 1'b1, 4'd11, 32'd0} && 1'b0) begin end
    if (got !== {1'b0, 1'b0, 4'd11, 32'd0}) begin
      errors++; $display("FAIL en_resume got=%h exp=%h", got, {1'b0, 1'b0, 4'd11, 32'd0});
    end
  endtask

`ifdef ALU_OVF_FLAG_EN
  task automatic test_ovf;
    vec_t q[$];
    logic ovf_exp[5];
    logic [32:0] got, exp;
    ovf_exp[0] = 1'b1; ovf_exp[1] = 1'b1; ovf_exp[2] = 1'b0; ovf_exp[3] = 1'b0; ovf_exp[4] = 1'b0;
    q.push_back('{"ovf_add",     3'b000, 3'b000, 1'b0, 32'h7FFFFFFF, 32'd1,        4'd0, 1'b0, 32'h80000000});
    q.push_back('{"ovf_sub",     3'b010, 3'b000, 1'b1, 32'h80000000, 32'd1,        4'd1, 1'b0, 32'h7FFFFFFF});
    q.push_back('{"ovf_add_ok",  3'b010, 3'b000, 1'b0, 32'd1,        32'd1,        4'd0, 1'b0, 32'd2});
    q.push_back('{"ovf_slt",     3'b010, 3'b010, 1'b0, 32'h7FFFFFFF, 32'hFFFFFFFF, 4'd3, 1'b0, 32'd0});
    q.push_back('{"ovf_sub_ok",  3'b010, 3'b000, 1'b1, 32'd5,        32'd7,        4'd1, 1'b0, 32'hFFFFFFFE});
    foreach (q[i]) begin
      drive(q[i], 1'b1);
      got = {ovf, alu_o};
      exp = {ovf_exp[i], q[i].res};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL %s got=%h exp=%h", q[i].name, got, exp); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_r_type();
    test_i_type();
    test_branch();
    test_other_classes();
    test_back_to_back();
    test_enable_hold();
`ifdef ALU_OVF_FLAG_EN
    test_ovf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
